// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Holds the FSM state encoding and the grant encoding.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_e;

    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable 4-bit down-counter that times the memory latency window.
// expire_o flags the last counted cycle (count == 1).
module arb_lat_counter
    import unified_mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 expire_o
);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch port and the
// load/store port, sequencing each access as ISSUE -> WAIT -> RESP and stalling the pipe meanwhile.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              busy,
    output logic              err
);

    // WAIT lasts exactly MEM_LAT cycles so the capture lands in cycle ISSUE+MEM_LAT.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);

    arb_state_e            state_q, state_d;
    arb_gnt_e              gnt_q;
    arb_gnt_e              last_gnt_q;
    arb_gnt_e              gnt_sel;
    logic                  take_gnt;
    logic                  dm_pend;
    logic                  lat_expire;
    logic                  capture;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic [DATA_W-1:0]     dm_rdata_q;
    logic                  err_q;

    assign dm_pend = dm_read | dm_write;

    always_comb begin
        state_d  = state_q;
        take_gnt = 1'b0;
        gnt_sel  = GNT_IF;
        case (state_q)
            ST_IDLE: begin
                // Under contention the port that did not win last time gets the grant.
                if (dm_pend && (!if_req || (last_gnt_q == GNT_IF))) begin
                    take_gnt = 1'b1;
                    gnt_sel  = GNT_DM;
                end else if (if_req) begin
                    take_gnt = 1'b1;
                    gnt_sel  = GNT_IF;
                end
                if (take_gnt) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lat_expire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign capture = (state_q == ST_WAIT) && lat_expire;

    arb_lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_ISSUE),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q == ST_WAIT),
        .expire_o   (lat_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            last_gnt_q  <= GNT_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_gnt) begin
                gnt_q      <= gnt_sel;
                last_gnt_q <= gnt_sel;
                if (gnt_sel == GNT_DM) begin
                    mem_addr_q  <= dm_addr;
                    mem_wdata_q <= dm_wdata;
                    mem_we_q    <= dm_write;
                    if (dm_read && dm_write) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    mem_addr_q  <= if_addr;
                    mem_wdata_q <= '0;
                    mem_we_q    <= 1'b0;
                end
            end
            // Stores keep uniform timing but never disturb the load data register.
            if (capture && !mem_we_q) begin
                if (gnt_q == GNT_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_en     = (state_q == ST_ISSUE);
    assign mem_we     = mem_en & mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_done    = (state_q == ST_RESP) && (gnt_q == GNT_IF);
    assign dm_done    = (state_q == ST_RESP) && (gnt_q == GNT_DM);
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign pipe_stall = (if_req & ~if_done) | (dm_pend & ~dm_done);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1,
// each with a small fixed-latency memory model driving mem_rdata only in its valid cycle.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, dm_done, mem_en, mem_we, pipe_stall, busy, err;

    logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        if_done_1, dm_done_1, mem_en_1, mem_we_1, pipe_stall_1, busy_1, err_1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall), .busy(busy), .err(err)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1), .if_done(if_done_1),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata_1), .dm_done(dm_done_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .pipe_stall(pipe_stall_1), .busy(busy_1), .err(err_1)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C220004;
        return {a[15:0], 16'hC0DE};
    endfunction

    logic        v1, v2, w1;
    logic [31:0] d1, d2, e1;

    always @(posedge clk) begin
        v1 <= mem_en;
        d1 <= mem_word(mem_addr);
        v2 <= v1;
        d2 <= d1;
        w1 <= mem_en_1;
        e1 <= mem_word(mem_addr_1);
    end

    assign mem_rdata   = (v2 === 1'b1) ? d2 : GARBAGE;
    assign mem_rdata_1 = (w1 === 1'b1) ? e1 : GARBAGE;

    // ---------------- driver / checker ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        dm_read  = 1'b0;
        dm_write = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        // Reset held two cycles with a pending fetch
        step(2);
        check_eq("rst_mem_en",  32'(mem_en),  32'd0);
        check_eq("rst_if_done", 32'(if_done), 32'd0);
        check_eq("rst_busy",    32'(busy),    32'd0);
        check_eq("rst_err",     32'(err),     32'd0);
        check_eq("rst_stall",   32'(pipe_stall), 32'd1);
        rst = 1'b0;                                   // cycle 0

        // Single fetch, MEM_LAT=2
        step(1);                                      // cycle 1
        check_eq("f_mem_en",   32'(mem_en),     32'd1);
        check_eq("f_mem_addr", mem_addr,        32'h10);
        check_eq("f_mem_we",   32'(mem_we),     32'd0);
        check_eq("f_busy",     32'(busy),       32'd1);
        check_eq("f_stall",    32'(pipe_stall), 32'd1);
        step(1);                                      // cycle 2
        check_eq("f_en_once",  32'(mem_en),  32'd0);
        check_eq("f_no_done2", 32'(if_done), 32'd0);
        step(1);                                      // cycle 3
        check_eq("f_no_done3", 32'(if_done), 32'd0);
        step(1);                                      // cycle 4
        check_eq("f_done",     32'(if_done),    32'd1);
        check_eq("f_rdata",    if_rdata,        32'h8C220004);
        check_eq("f_stall_rel",32'(pipe_stall), 32'd0);
        if_req = 1'b0;
        step(1);                                      // cycle 5
        check_eq("f_done_pulse", 32'(if_done), 32'd0);
        check_eq("f_idle",       32'(busy),    32'd0);
        check_eq("f_rdata_hold", if_rdata,     32'h8C220004);

        // Contention from reset: DM first, then IF
        rst = 1'b1; if_req = 1'b1; dm_read = 1'b1; dm_addr = 32'h40;
        step(1);
        rst = 1'b0;                                   // cycle 0
        step(1);                                      // cycle 1
        check_eq("c_mem_en1",  32'(mem_en), 32'd1);
        check_eq("c_addr_dm",  mem_addr,    32'h40);
        step(3);                                      // cycle 4
        check_eq("c_dm_done",  32'(dm_done), 32'd1);
        check_eq("c_if_wait",  32'(if_done), 32'd0);
        check_eq("c_dm_rdata", dm_rdata,     32'h0040C0DE);
        check_eq("c_stall_if", 32'(pipe_stall), 32'd1);
        dm_read = 1'b0;
        step(1);                                      // cycle 5
        check_eq("c_idle5",    32'(busy),   32'd0);
        step(1);                                      // cycle 6
        check_eq("c_mem_en6",  32'(mem_en), 32'd1);
        check_eq("c_addr_if",  mem_addr,    32'h10);
        step(3);                                      // cycle 9
        check_eq("c_if_done",  32'(if_done), 32'd1);
        check_eq("c_if_rdata", if_rdata,     32'h8C220004);

        // Store after the fetch; dm_rdata must keep the earlier load value
        if_req = 1'b0; dm_write = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
        step(2);                                      // cycle 11
        check_eq("s_mem_en",   32'(mem_en), 32'd1);
        check_eq("s_mem_we",   32'(mem_we), 32'd1);
        check_eq("s_mem_addr", mem_addr,    32'h80);
        check_eq("s_wdata",    mem_wdata,   32'hDEADBEEF);
        dm_addr = 32'h99; dm_wdata = 32'h0;
        step(1);                                      // cycle 12
        check_eq("s_en_once",  32'(mem_en), 32'd0);
        check_eq("s_we_qual",  32'(mem_we), 32'd0);
        check_eq("s_addr_held",mem_addr,    32'h80);
        step(2);                                      // cycle 14
        check_eq("s_dm_done",  32'(dm_done), 32'd1);
        check_eq("s_rdata_keep", dm_rdata,   32'h0040C0DE);
        check_eq("s_err",      32'(err),     32'd0);

        // Reset in the WAIT cycle, then a clean re-request
        dm_write = 1'b0; dm_read = 1'b1; dm_addr = 32'h44;
        step(2);                                      // ISSUE
        check_eq("r_mem_addr", mem_addr,   32'h44);
        step(1);                                      // WAIT
        check_eq("r_busy_w",   32'(busy),  32'd1);
        rst = 1'b1;
        step(1);
        check_eq("r_busy0",    32'(busy),    32'd0);
        check_eq("r_no_done",  32'(dm_done), 32'd0);
        check_eq("r_rdata0",   dm_rdata,     32'h0);
        rst = 1'b0;                                   // cycle 0 of re-request
        step(1);
        check_eq("r_mem_en",   32'(mem_en),  32'd1);
        check_eq("r_no_done1", 32'(dm_done), 32'd0);
        step(2);
        check_eq("r_no_done3", 32'(dm_done), 32'd0);
        step(1);                                      // cycle 4
        check_eq("r_dm_done",  32'(dm_done), 32'd1);
        check_eq("r_dm_rdata", dm_rdata,     32'h0044C0DE);
        dm_read = 1'b0;

        // Illegal read+write: write issued, sticky err
        rst = 1'b1; dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
        step(1);
        rst = 1'b0;                                   // cycle 0
        step(1);                                      // cycle 1
        check_eq("i_mem_we",   32'(mem_we),   32'd1);
        check_eq("i_wdata",    mem_wdata,     32'h12345678);
        check_eq("i_err",      32'(err),      32'd1);
        check_eq("i_mem_we_l1",32'(mem_we_1), 32'd1);
        step(2);                                      // cycle 3
        check_eq("i_done_l1",  32'(dm_done_1), 32'd1);
        check_eq("i_rdata_l1", dm_rdata_1,     32'h0);
        check_eq("i_nodone3",  32'(dm_done),   32'd0);
        step(1);                                      // cycle 4
        check_eq("i_dm_done",  32'(dm_done),   32'd1);
        check_eq("i_rdata",    dm_rdata,       32'h0);
        dm_read = 1'b0; dm_write = 1'b0;
        step(3);
        check_eq("i_err_hold", 32'(err),   32'd1);
        check_eq("i_err_l1",   32'(err_1), 32'd1);
        check_eq("i_idle",     32'(busy),  32'd0);

        // MEM_LAT=1 fetch completes three cycles after the request
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        step(1);
        check_eq("l1_err_clr", 32'(err),   32'd0);
        check_eq("l1_err_clr1",32'(err_1), 32'd0);
        rst = 1'b0;                                   // cycle 0
        step(2);                                      // cycle 2
        check_eq("l1_nodone2", 32'(if_done_1), 32'd0);
        step(1);                                      // cycle 3
        check_eq("l1_done",    32'(if_done_1), 32'd1);
        check_eq("l1_rdata",   if_rdata_1,     32'h8C220004);
        check_eq("l2_nodone3", 32'(if_done),   32'd0);
        if_req = 1'b0;
        step(1);                                      // cycle 4
        check_eq("l1_pulse",   32'(if_done_1), 32'd0);
        check_eq("l1_idle",    32'(busy_1),    32'd0);
        check_eq("l2_done4",   32'(if_done),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
